// File: rtl/register_writeback_pkg.sv
// Shared widths and queue entry type for the register-file writeback path.
// Imported by the writeback queue and the writeback top.
package riscv_wb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/register_writeback_fifo.sv
// In-order writeback queue: up to two pushes and one pop per cycle.
// Storage is exported so the top can run the forwarding search.
module wb_fifo
  import riscv_wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push0,
  input  wb_entry_t push0_entry,
  input  logic      push1,
  input  wb_entry_t push1_entry,
  input  logic      pop,
  output wb_entry_t head_entry,
  output logic [PW-1:0] head_ptr,
  output logic [CW-1:0] count,
  output wb_entry_t entries [DEPTH]
);

  wb_entry_t         mem_q [DEPTH];
  wb_entry_t         mem_d [DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;

  // push1 is only ever raised together with push0 (compacted upstream)
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push0) begin
      mem_d[tail_q] = push0_entry;
      tail_d        = tail_q + PW'(1);
    end
    if (push1) begin
      mem_d[tail_q + PW'(1)] = push1_entry;
      tail_d                 = tail_q + PW'(2);
    end
    if (pop) begin
      head_d = head_q + PW'(1);
    end
    count_d = count_q + CW'(push0) + CW'(push1) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  assign head_entry = mem_q[head_q];
  assign head_ptr   = head_q;
  assign count      = count_q;
  assign entries    = mem_q;

endmodule

// File: rtl/register_writeback.sv
// Register-file write initiator: arbitrates mem/ALU results into an
// in-order queue, drains one write per cycle, and forwards pending values.
module register_writeback
  import riscv_wb_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = riscv_wb_pkg::DATA_W,
  parameter  int ADDR_W = riscv_wb_pkg::ADDR_W,
  localparam int PW     = $clog2(DEPTH),
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memValid,
  input  logic [ADDR_W-1:0] memRd,
  input  logic [DATA_W-1:0] memData,
  output logic              memReady,
  input  logic              aluValid,
  input  logic [ADDR_W-1:0] aluRd,
  input  logic [DATA_W-1:0] aluData,
  output logic              aluReady,
  output logic              rWrite,
  output logic [31:0]       rsWrite,
  output logic [DATA_W-1:0] dataWrite,
  input  logic [ADDR_W-1:0] fwdRs1,
  input  logic [ADDR_W-1:0] fwdRs2,
  output logic              fwdHit1,
  output logic              fwdHit2,
  output logic [DATA_W-1:0] fwdData1,
  output logic [DATA_W-1:0] fwdData2,
  output logic [CW-1:0]     pendingCount
);

  logic          push0, push1, pop;
  wb_entry_t     push0_entry, push1_entry;
  wb_entry_t     mem_entry, alu_entry;
  wb_entry_t     head_entry;
  wb_entry_t     entries [DEPTH];
  logic [PW-1:0] head_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic          mem_take, alu_take;

  // free ignores the same-cycle pop so readies never depend on drain
  assign free     = CW'(DEPTH) - count;
  assign memReady = rst_n & (free >= CW'(1));
  assign aluReady = rst_n & ((free >= CW'(2)) |
                    ((free >= CW'(1)) & ~memValid));

  // x0 writes complete the handshake but never enter the queue
  assign mem_take = memValid & memReady & (memRd != '0);
  assign alu_take = aluValid & aluReady & (aluRd != '0);

  assign mem_entry = '{rd: memRd, data: memData};
  assign alu_entry = '{rd: aluRd, data: aluData};

  assign push0       = mem_take | alu_take;
  assign push0_entry = mem_take ? mem_entry : alu_entry;
  assign push1       = mem_take & alu_take;
  assign push1_entry = alu_entry;

  assign rWrite = (count != '0);
  assign pop    = rWrite;

  assign rsWrite   = rWrite ? 32'(head_entry.rd) : 32'd0;
  assign dataWrite = rWrite ? head_entry.data : '0;

  assign pendingCount = count;

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push0      (push0),
    .push0_entry(push0_entry),
    .push1      (push1),
    .push1_entry(push1_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .head_ptr   (head_ptr),
    .count      (count),
    .entries    (entries)
  );

  // walk oldest to youngest so the last match wins
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    fwdHit1  = 1'b0;
    fwdHit2  = 1'b0;
    fwdData1 = '0;
    fwdData2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_ptr + PW'(k);
      if (CW'(k) < count) begin
        if ((fwdRs1 != '0) && (entries[idx].rd == fwdRs1)) begin
          fwdHit1  = 1'b1;
          fwdData1 = entries[idx].data;
        end
        if ((fwdRs2 != '0) && (entries[idx].rd == fwdRs2)) begin
          fwdHit2  = 1'b1;
          fwdData2 = entries[idx].data;
        end
      end
    end
  end

endmodule

// File: tb/tb_register_writeback.sv
// Randomized bench for register_writeback against a queue-based model.
// Directed scenarios first, then random two-source traffic.
module tb_register_writeback;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          memValid = 1'b0;
  logic [AW-1:0] memRd = '0;
  logic [DW-1:0] memData = '0;
  logic          memReady;
  logic          aluValid = 1'b0;
  logic [AW-1:0] aluRd = '0;
  logic [DW-1:0] aluData = '0;
  logic          aluReady;
  logic          rWrite;
  logic [31:0]   rsWrite;
  logic [DW-1:0] dataWrite;
  logic [AW-1:0] fwdRs1 = '0;
  logic [AW-1:0] fwdRs2 = '0;
  logic          fwdHit1, fwdHit2;
  logic [DW-1:0] fwdData1, fwdData2;
  logic [CW-1:0] pendingCount;

  always #5 clk = ~clk;

  register_writeback #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .memValid    (memValid),
    .memRd       (memRd),
    .memData     (memData),
    .memReady    (memReady),
    .aluValid    (aluValid),
    .aluRd       (aluRd),
    .aluData     (aluData),
    .aluReady    (aluReady),
    .rWrite      (rWrite),
    .rsWrite     (rsWrite),
    .dataWrite   (dataWrite),
    .fwdRs1      (fwdRs1),
    .fwdRs2      (fwdRs2),
    .fwdHit1     (fwdHit1),
    .fwdHit2     (fwdHit2),
    .fwdData1    (fwdData1),
    .fwdData2    (fwdData2),
    .pendingCount(pendingCount)
  );

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  ent_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int free_slots();
    return DEPTH - q.size();
  endfunction

  function automatic bit exp_mem_rdy();
    return free_slots() >= 1;
  endfunction

  function automatic bit exp_alu_rdy(bit mv);
    return (free_slots() >= 2) || (free_slots() >= 1 && !mv);
  endfunction

  task automatic check_outs();
    int            sz;
    logic          eh1, eh2;
    logic [DW-1:0] ed1, ed2;
    sz  = q.size();
    eh1 = 1'b0; eh2 = 1'b0;
    ed1 = '0;   ed2 = '0;
    for (int i = 0; i < sz; i++) begin
      if (fwdRs1 != 0 && q[i].rd == fwdRs1) begin
        eh1 = 1'b1; ed1 = q[i].data;
      end
      if (fwdRs2 != 0 && q[i].rd == fwdRs2) begin
        eh2 = 1'b1; ed2 = q[i].data;
      end
    end
    chk("rWrite", 64'(rWrite), 64'(sz != 0));
    chk("rsWrite", 64'(rsWrite), sz != 0 ? 64'(q[0].rd) : 64'd0);
    chk("dataWrite", 64'(dataWrite), sz != 0 ? 64'(q[0].data) : 64'd0);
    chk("pendingCount", 64'(pendingCount), 64'(sz));
    chk("memReady", 64'(memReady), 64'(exp_mem_rdy()));
    chk("aluReady", 64'(aluReady), 64'(exp_alu_rdy(memValid)));
    chk("fwdHit1", 64'(fwdHit1), 64'(eh1));
    chk("fwdData1", 64'(fwdData1), 64'(ed1));
    chk("fwdHit2", 64'(fwdHit2), 64'(eh2));
    chk("fwdData2", 64'(fwdData2), 64'(ed2));
  endtask

  task automatic step(input bit mv, input logic [AW-1:0] mrd,
                      input logic [DW-1:0] md, input bit av,
                      input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                      input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    bit macc, aacc;
    @(negedge clk);
    memValid = mv; memRd = mrd; memData = md;
    aluValid = av; aluRd = ard; aluData = ad;
    fwdRs1 = r1; fwdRs2 = r2;
    #1;
    check_outs();
    macc = mv && exp_mem_rdy();
    aacc = av && exp_alu_rdy(mv);
    @(posedge clk);
    if (q.size() != 0) void'(q.pop_front());
    if (macc && mrd != 0) q.push_back('{rd: mrd, data: md});
    if (aacc && ard != 0) q.push_back('{rd: ard, data: ad});
  endtask

  task automatic idle(input int n, input logic [AW-1:0] r1);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, r1, 0);
  endtask

  task automatic check_reset_outs(string tag);
    chk({tag, "_rWrite"}, 64'(rWrite), 64'd0);
    chk({tag, "_rsWrite"}, 64'(rsWrite), 64'd0);
    chk({tag, "_dataWrite"}, 64'(dataWrite), 64'd0);
    chk({tag, "_pending"}, 64'(pendingCount), 64'd0);
    chk({tag, "_memReady"}, 64'(memReady), 64'd0);
    chk({tag, "_aluReady"}, 64'(aluReady), 64'd0);
    chk({tag, "_fwdHit1"}, 64'(fwdHit1), 64'd0);
    chk({tag, "_fwdData1"}, 64'(fwdData1), 64'd0);
  endtask

  initial begin
    // reset with valids offered: readies must stay low
    memValid = 1'b1; aluValid = 1'b1; fwdRs1 = 5'd3;
    #12;
    check_reset_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    memValid = 1'b0; aluValid = 1'b0;

    // single ALU write
    step(0, 0, 0, 1, 5, 32'h1234, 5, 0);
    idle(3, 5);

    // same rd from both sources in one cycle
    step(1, 3, 32'hA, 1, 3, 32'hB, 3, 3);
    idle(3, 3);

    // x0 writes are accepted and dropped
    step(0, 0, 0, 1, 0, 32'hFFFF, 0, 0);
    step(1, 0, 32'h55, 1, 0, 32'h66, 0, 0);
    idle(2, 0);

    // sustained dual-source pressure to exercise free=1 and wrap
    for (int i = 0; i < 10; i++) begin
      step(1, AW'(1 + i % 7), DW'(32'h100 + i), 1, AW'(2 + i % 5),
           DW'(32'h200 + i), AW'(1 + i % 7), AW'(2 + i % 5));
    end
    idle(5, 0);

    // async reset mid-drain with three pending entries
    step(1, 7, 32'h70, 1, 8, 32'h80, 7, 8);
    step(1, 9, 32'h90, 1, 10, 32'hA0, 9, 10);
    @(negedge clk);
    memValid = 1'b1; aluValid = 1'b1; fwdRs1 = 5'd9;
    #1;
    chk("pre_reset_pending", 64'(pendingCount), 64'(q.size()));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outs("midreset");
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    memValid = 1'b0; aluValid = 1'b0;
    idle(3, 9);

    // random traffic with aliasing rd and x0
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
           AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    end
    idle(6, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
